dmux1t8_8_reg: RTL and testbench
================================

# dmux1t8_8_reg

Registered 1-to-8 byte demultiplexer: distributes a single 8-bit input stream into eight held output registers, selected either by an explicit 3-bit address or by an internal auto-incrementing slot pointer. It sits on the write side of the 8-to-1 byte multiplexer path, filling the eight source bytes the multiplexer later selects from. A 3-bit select applied to both blocks therefore round-trips data. Per-slot valid flags, a full flag and a wrap pulse let upstream logic sequence a complete frame of eight bytes.

## Interface
- WIDTH, 8, data width of the input and of each output slot.
- clk  input  1  rising-edge clock, the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- I  input  WIDTH  write data.
- s  input  3  explicit slot address, used only when auto = 0.
- wr  input  1  write strobe, sampled on rising clk.
- auto  input  1  1 = write to the slot at ptr and advance ptr; 0 = write to the slot at s.
- clr  input  1  synchronous clear of valid flags and ptr; slot data is held.
- O0..O7  output  WIDTH each  registered slot contents.
- valid  output  8  valid[k] = 1 once slot k has been written since the last reset or clr.
- full  output  1  1 when valid == 8'hFF.
- ptr  output  3  current auto-mode slot pointer.
- wrap  output  1  one-cycle pulse, asserted the cycle after an auto-mode write to slot 7.

## Operation
- Reset (rst_n = 0, asynchronous, takes effect immediately): O0..O7 = 0, valid = 0, ptr = 0, wrap = 0. full = 0 as a consequence.
- Target slot each cycle: tgt = auto ? ptr : s.
- wr = 1, clr = 0 at a rising edge:
  - O[tgt] <= I.
  - valid[tgt] <= 1.
  - All other slots and valid bits hold.
- In auto mode a write also advances ptr: ptr <= ptr + 1 modulo 8, so 7 wraps to 0. A write in auto mode with ptr = 7 sets wrap = 1 for the next cycle.
- In manual mode (auto = 0) ptr holds. A manual write never asserts wrap.
- wr = 0: all registers hold and wrap <= 0.
- clr = 1 at a rising edge: valid <= 0, ptr <= 0, wrap <= 0. O0..O7 hold their data.
- clr and wr in the same cycle: clr wins. The write is dropped: no slot data change, no valid set, ptr ends at 0.
- Rewriting a slot that is already valid overwrites its data; valid stays 1 and full is unaffected.
- Toggling auto between writes is legal:
  - ptr keeps its value across manual-mode cycles.
  - Auto mode resumes from the held ptr.
- full is combinational from valid; there is no extra register stage.
- full does not block writes. There is no back-pressure: every wr is accepted.
- Reset mid-frame discards everything: all data, flags and ptr return to their reset values immediately, independent of clk.

## Timing
- Write latency is 1 cycle. Data on I at the rising edge where wr = 1 appears on O[tgt] immediately after that edge.
- valid, ptr and full update on the same edge as the data.
- wrap is high for exactly one cycle: the cycle following the edge that wrote slot 7 in auto mode.
- s, auto, I, wr and clr must be stable around the rising edge. They have no effect between edges.
- Back-to-back writes every cycle are supported at full rate. Eight consecutive auto writes fill a frame in 8 cycles.
- rst_n assertion is asynchronous; deassertion is expected synchronous to clk, provided externally.

## Test plan
- **Reset values:** assert rst_n = 0 mid-simulation with wr = 1 → O0..O7 = 8'h00, valid = 8'h00, ptr = 0, full = 0, wrap = 0, all immediately and without waiting for a clock edge.
- **Manual fill:** auto = 0; write I = 8'hA0, 51, A2, 53, A4, 55, A6, 57 with s = 0..7 on consecutive cycles → O0..O7 hold those values, valid = 8'hFF, full = 1 after the 8th edge, ptr = 0, wrap never asserted.
- **Auto fill and wrap:**
  - auto = 1; 8 consecutive writes of 8'h10..8'h17 → Ok = 8'h10 + k, and ptr counts 0→7→0.
  - wrap = 1 for exactly the one cycle after the 8th write.
  - A 9th write of 8'hFF → O0 = 8'hFF, valid stays 8'hFF.
- **clr versus wr collision:**
  - After a full frame, assert clr = 1 and wr = 1 with auto = 1, I = 8'h99 → valid = 0, ptr = 0, full = 0, and all O data unchanged (8'h99 is not written anywhere).
  - A following auto write of 8'h42 → O0 = 8'h42, valid = 8'h01.
- **Mixed mode:**
  - Do 3 auto writes (ptr = 3), then a manual write s = 6, I = 8'hC6 → O6 = 8'hC6 and ptr stays 3.
  - Next auto write, I = 8'h33 → O3 = 8'h33 and ptr = 4.
- **Round trip:** after the manual fill above, feed O0..O7 into the 8-to-1 byte multiplexer and sweep its select 0..7 every 50 ns → its output reads 8'hA0, 51, A2, 53, A4, 55, A6, 57 in order.

Source files
------------

// File: rtl/dmux1t8_8_reg.sv
// Registered 1-to-8 demultiplexer: routes I into one of eight held slots, chosen by s or by
// an auto-incrementing pointer, with per-slot valid flags, a full flag and a frame wrap pulse.
module dmux1t8_8_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] I,
    input  logic [2:0]       s,
    input  logic             wr,
    input  logic             auto,
    input  logic             clr,
    output logic [WIDTH-1:0] O0,
    output logic [WIDTH-1:0] O1,
    output logic [WIDTH-1:0] O2,
    output logic [WIDTH-1:0] O3,
    output logic [WIDTH-1:0] O4,
    output logic [WIDTH-1:0] O5,
    output logic [WIDTH-1:0] O6,
    output logic [WIDTH-1:0] O7,
    output logic [7:0]       valid,
    output logic             full,
    output logic [2:0]       ptr,
    output logic             wrap
);

    logic [7:0]         valid_q, valid_d;
    logic [2:0]         ptr_q, ptr_d;
    logic               wrap_q, wrap_d;
    logic [2:0]         tgt;
    logic               do_write;
    logic [7:0]         slot_we;
    logic [8*WIDTH-1:0] slot_flat;

    assign tgt      = auto ? ptr_q : s;
    // clr takes priority, so a colliding write never reaches any slot
    assign do_write = wr & ~clr;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_slot
            logic [WIDTH-1:0] data_q, data_d;

            assign slot_we[gi] = do_write && (tgt == 3'(gi));

            always_comb begin
                data_d = data_q;
                if (slot_we[gi]) begin
                    data_d = I;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_q <= '0;
                end else begin
                    data_q <= data_d;
                end
            end

            assign slot_flat[gi*WIDTH +: WIDTH] = data_q;
        end
    endgenerate

    always_comb begin
        valid_d = valid_q;
        ptr_d   = ptr_q;
        wrap_d  = 1'b0;
        if (clr) begin
            valid_d = '0;
            ptr_d   = '0;
        end else if (wr) begin
            valid_d = valid_q | slot_we;
            if (auto) begin
                ptr_d  = ptr_q + 3'd1;
                wrap_d = (ptr_q == 3'd7);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            ptr_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
            wrap_q  <= wrap_d;
        end
    end

    assign O0    = slot_flat[0*WIDTH +: WIDTH];
    assign O1    = slot_flat[1*WIDTH +: WIDTH];
    assign O2    = slot_flat[2*WIDTH +: WIDTH];
    assign O3    = slot_flat[3*WIDTH +: WIDTH];
    assign O4    = slot_flat[4*WIDTH +: WIDTH];
    assign O5    = slot_flat[5*WIDTH +: WIDTH];
    assign O6    = slot_flat[6*WIDTH +: WIDTH];
    assign O7    = slot_flat[7*WIDTH +: WIDTH];
    assign valid = valid_q;
    assign full  = &valid_q;
    assign ptr   = ptr_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_dmux1t8_8_reg.sv
// Bench for dmux1t8_8_reg: table-driven fills, hand-written corner sequences and random
// traffic checked against a slot-array reference model.
module tb_dmux1t8_8_reg;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] I;
    logic [2:0] s;
    logic       wr, auto, clr;
    logic [7:0] o0, o1, o2, o3, o4, o5, o6, o7;
    logic [7:0] valid;
    logic       full;
    logic [2:0] ptr;
    logic       wrap;
    logic [7:0] dut_o [8];

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    logic [7:0] m_o [8];
    bit         m_v [8];
    int         m_ptr;
    bit         m_wrap;

    always #5 clk = ~clk;

    dmux1t8_8_reg #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .I(I), .s(s), .wr(wr), .auto(auto), .clr(clr),
        .O0(o0), .O1(o1), .O2(o2), .O3(o3), .O4(o4), .O5(o5), .O6(o6), .O7(o7),
        .valid(valid), .full(full), .ptr(ptr), .wrap(wrap)
    );

    always_comb begin
        dut_o[0] = o0; dut_o[1] = o1; dut_o[2] = o2; dut_o[3] = o3;
        dut_o[4] = o4; dut_o[5] = o5; dut_o[6] = o6; dut_o[7] = o7;
    end

    typedef struct {
        logic       w, a, c;
        logic [2:0] sel;
        logic [7:0] d;
        int         slot;
        logic [7:0] exp_v;
        logic [2:0] exp_p;
        logic       exp_w;
        logic       exp_f;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 8; k++) begin
            m_o[k] = 8'h00;
            m_v[k] = 1'b0;
        end
        m_ptr  = 0;
        m_wrap = 1'b0;
    endtask

    task automatic model_step(input logic w, input logic a, input logic c,
                              input logic [2:0] sel, input logic [7:0] d);
        int t;
        if (c) begin
            for (int k = 0; k < 8; k++) m_v[k] = 1'b0;
            m_ptr  = 0;
            m_wrap = 1'b0;
        end else if (w) begin
            t = a ? m_ptr : int'(sel);
            m_o[t] = d;
            m_v[t] = 1'b1;
            m_wrap = a && (m_ptr == 7);
            if (a) m_ptr = (m_ptr + 1) % 8;
        end else begin
            m_wrap = 1'b0;
        end
    endtask

    function automatic logic [7:0] model_valid();
        logic [7:0] v;
        for (int k = 0; k < 8; k++) v[k] = m_v[k];
        return v;
    endfunction

    function automatic logic model_full();
        int n = 0;
        for (int k = 0; k < 8; k++) n += int'(m_v[k]);
        return n == 8;
    endfunction

    task automatic check_model();
        for (int k = 0; k < 8; k++) chk($sformatf("model_O%0d", k), 32'(dut_o[k]), 32'(m_o[k]));
        chk("model_valid", 32'(valid), 32'(model_valid()));
        chk("model_full",  32'(full),  32'(model_full()));
        chk("model_ptr",   32'(ptr),   32'(m_ptr));
        chk("model_wrap",  32'(wrap),  32'(m_wrap));
    endtask

    task automatic cyc(input logic w, input logic a, input logic c,
                       input logic [2:0] sel, input logic [7:0] d);
        wr = w; auto = a; clr = c; s = sel; I = d;
        @(posedge clk);
        model_step(w, a, c, sel, d);
        #1;
        check_model();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    endtask

    function automatic logic [7:0] mux8(input int sel);
        return dut_o[sel];
    endfunction

    initial begin
        logic [7:0] man_data [8];
        logic [7:0] fill_v   [8];
        man_data = '{8'hA0, 8'h51, 8'hA2, 8'h53, 8'hA4, 8'h55, 8'hA6, 8'h57};
        fill_v   = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};
        for (int k = 0; k < 8; k++) begin
            tbl[k]     = '{w: 1'b1, a: 1'b0, c: 1'b0, sel: 3'(k), d: man_data[k], slot: k,
                           exp_v: fill_v[k], exp_p: 3'd0, exp_w: 1'b0, exp_f: (k == 7)};
            tbl[k + 8] = '{w: 1'b1, a: 1'b1, c: 1'b0, sel: 3'(7 - k), d: 8'(8'h10 + k), slot: k,
                           exp_v: fill_v[k], exp_p: 3'((k + 1) % 8), exp_w: (k == 7),
                           exp_f: (k == 7)};
        end

        rst_n = 1'b0; wr = 1'b0; auto = 1'b0; clr = 1'b0; s = 3'd0; I = 8'h00;
        model_reset();
        #12 rst_n = 1'b1;
        #1 check_model();

        // manual fill
        for (int i = 0; i < 8; i++) begin
            cyc(tbl[i].w, tbl[i].a, tbl[i].c, tbl[i].sel, tbl[i].d);
            chk($sformatf("man_data%0d", i), 32'(dut_o[tbl[i].slot]), 32'(tbl[i].d));
            chk($sformatf("man_valid%0d", i), 32'(valid), 32'(tbl[i].exp_v));
            chk($sformatf("man_ptr%0d", i), 32'(ptr), 32'(tbl[i].exp_p));
            chk($sformatf("man_wrap%0d", i), 32'(wrap), 32'(tbl[i].exp_w));
            chk($sformatf("man_full%0d", i), 32'(full), 32'(tbl[i].exp_f));
        end

        // round trip through an 8-to-1 selector, select stepped every 50 ns
        for (int sel = 0; sel < 8; sel++) begin
            idle(5);
            chk($sformatf("roundtrip_sel%0d", sel), 32'(mux8(sel)), 32'(man_data[sel]));
        end

        // auto fill
        cyc(1'b0, 1'b0, 1'b1, 3'd0, 8'h00);
        for (int i = 8; i < 16; i++) begin
            cyc(tbl[i].w, tbl[i].a, tbl[i].c, tbl[i].sel, tbl[i].d);
            chk($sformatf("auto_data%0d", i - 8), 32'(dut_o[tbl[i].slot]), 32'(tbl[i].d));
            chk($sformatf("auto_valid%0d", i - 8), 32'(valid), 32'(tbl[i].exp_v));
            chk($sformatf("auto_ptr%0d", i - 8), 32'(ptr), 32'(tbl[i].exp_p));
            chk($sformatf("auto_wrap%0d", i - 8), 32'(wrap), 32'(tbl[i].exp_w));
            chk($sformatf("auto_full%0d", i - 8), 32'(full), 32'(tbl[i].exp_f));
        end

        // ninth write lands in slot 0 and wrap drops
        cyc(1'b1, 1'b1, 1'b0, 3'd5, 8'hFF);
        chk("ninth_O0", 32'(o0), 32'h0000_00FF);
        chk("ninth_valid", 32'(valid), 32'h0000_00FF);
        chk("ninth_wrap", 32'(wrap), 32'h0);

        // clr beats a simultaneous write
        cyc(1'b1, 1'b1, 1'b1, 3'd0, 8'h99);
        chk("coll_valid", 32'(valid), 32'h0);
        chk("coll_ptr", 32'(ptr), 32'h0);
        chk("coll_full", 32'(full), 32'h0);
        chk("coll_O0", 32'(o0), 32'h0000_00FF);
        for (int k = 1; k < 8; k++)
            chk($sformatf("coll_O%0d", k), 32'(dut_o[k]), 32'(8'h10 + k));
        cyc(1'b1, 1'b1, 1'b0, 3'd0, 8'h42);
        chk("post_coll_O0", 32'(o0), 32'h0000_0042);
        chk("post_coll_valid", 32'(valid), 32'h0000_0001);

        // mixed mode: manual write leaves ptr alone, auto resumes from it
        cyc(1'b0, 1'b0, 1'b1, 3'd0, 8'h00);
        for (int k = 0; k < 3; k++) cyc(1'b1, 1'b1, 1'b0, 3'd0, 8'(8'h20 + k));
        chk("mixed_ptr3", 32'(ptr), 32'h3);
        cyc(1'b1, 1'b0, 1'b0, 3'd6, 8'hC6);
        chk("mixed_O6", 32'(o6), 32'h0000_00C6);
        chk("mixed_ptr_hold", 32'(ptr), 32'h3);
        cyc(1'b1, 1'b1, 1'b0, 3'd1, 8'h33);
        chk("mixed_O3", 32'(o3), 32'h0000_0033);
        chk("mixed_ptr4", 32'(ptr), 32'h4);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 15) == 0), 3'($urandom_range(0, 7)),
                8'($urandom_range(0, 255)));
        end

        // asynchronous reset mid-frame with a write pending
        wr = 1'b1; auto = 1'b1; clr = 1'b0; I = 8'h5A;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < 8; k++) chk($sformatf("rst_O%0d", k), 32'(dut_o[k]), 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_full", 32'(full), 32'h0);
        chk("rst_ptr", 32'(ptr), 32'h0);
        chk("rst_wrap", 32'(wrap), 32'h0);
        @(posedge clk);
        #1 chk("rst_hold_O0", 32'(o0), 32'h0);
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k < 4; k++) cyc(1'b1, 1'b1, 1'b0, 3'd0, 8'(8'hE0 + k));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
